// File: rtl/cipher_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cipher_cfg_sequencer
// Purpose  : Loads a config word into the dual-XOR cipher core's serial chain
//            (capturing the previous chain contents), settles, gates the
//            TX/RX keystream enables and re-seeds the core after a
//            programmable number of enabled TX cycles.
// Revision : 1.0  initial release
// ============================================================================
module cipher_cfg_sequencer #(
  parameter int CFG_W      = 66,
  parameter int SETTLE_CYC = 2,
  parameter int REKEY_INT  = 0,
  parameter int CNT_W      = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_ready,
  input  logic             run_req,
  input  logic             tx_req,
  input  logic             rx_req,
  input  logic             cfg_o,
  output logic             cfg_en,
  output logic             cfg_i,
  output logic             tx_en,
  output logic             rx_en,
  output logic [CFG_W-1:0] rb_data,
  output logic             rb_valid,
  output logic             busy,
  output logic [7:0]       rekey_cnt
);

  localparam int BIT_W = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  // Interval target clipped to the counter range, so the counter saturating
  // at all-ones still produces a hit.
  localparam logic [CNT_W-1:0] C_REKEY_TGT =
    (64'(REKEY_INT) > ((64'd1 << CNT_W) - 64'd1)) ? C_CNT_MAX : CNT_W'(REKEY_INT);
  localparam logic C_REKEY_ON = (REKEY_INT != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t             state_q,     state_d;
  logic [CFG_W-1:0]   shadow_q,    shadow_d;
  // Holds the bits not yet presented on cfg_i (bit 0 is already on cfg_i).
  logic [CFG_W-2:0]   shift_q,     shift_d;
  // Holds readback bits captured so far; the last bit comes straight from cfg_o.
  logic [CFG_W-2:0]   rb_shift_q,  rb_shift_d;
  logic [BIT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic [3:0]         settle_q,    settle_d;
  logic [CNT_W-1:0]   int_cnt_q,   int_cnt_d;
  logic [7:0]         rekey_q,     rekey_d;
  logic [CFG_W-1:0]   rb_data_q,   rb_data_d;
  logic               rb_valid_q,  rb_valid_d;
  logic               cfg_en_q,    cfg_en_d;
  logic               cfg_i_q,     cfg_i_d;
  logic               tx_en_q,     tx_en_d;
  logic               rx_en_q,     rx_en_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               busy_q,      busy_d;

  logic accept;
  logic hit;
  logic reload;
  logic en_gate;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      shift_q     <= '0;
      rb_shift_q  <= '0;
      bit_cnt_q   <= '0;
      settle_q    <= '0;
      int_cnt_q   <= '0;
      rekey_q     <= '0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
      cfg_en_q    <= 1'b0;
      cfg_i_q     <= 1'b0;
      tx_en_q     <= 1'b0;
      rx_en_q     <= 1'b0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      shift_q     <= shift_d;
      rb_shift_q  <= rb_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      settle_q    <= settle_d;
      int_cnt_q   <= int_cnt_d;
      rekey_q     <= rekey_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
      cfg_en_q    <= cfg_en_d;
      cfg_i_q     <= cfg_i_d;
      tx_en_q     <= tx_en_d;
      rx_en_q     <= rx_en_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, shift/readback datapath, rekey counting and output enables.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    shift_d    = shift_q;
    rb_shift_d = rb_shift_q;
    bit_cnt_d  = bit_cnt_q;
    settle_d   = settle_q;
    rekey_d    = rekey_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    cfg_en_d   = 1'b0;
    cfg_i_d    = 1'b0;
    reload     = 1'b0;

    accept = cfg_valid & cfg_ready_q;
    hit    = C_REKEY_ON && (state_q == S_RUN) && (int_cnt_q >= C_REKEY_TGT);

    case (state_q)
      S_IDLE, S_RUN: begin
        if (accept) begin
          // A host word always beats a pending rekey.
          shadow_d  = cfg_data;
          shift_d   = cfg_data[CFG_W-1:1];
          cfg_i_d   = cfg_data[0];
          cfg_en_d  = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end else if (hit) begin
          reload    = 1'b1;
          shift_d   = shadow_q[CFG_W-1:1];
          cfg_i_d   = shadow_q[0];
          cfg_en_d  = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
          if (rekey_q != 8'hFF) rekey_d = rekey_q + 8'd1;
        end else if ((state_q == S_RUN) && !run_req) begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q == BIT_W'(CFG_W - 1)) begin
          rb_data_d  = {cfg_o, rb_shift_q};
          rb_valid_d = 1'b1;
          settle_d   = '0;
          state_d    = S_SETTLE;
        end else begin
          rb_shift_d = {cfg_o, rb_shift_q[CFG_W-2:1]};
          shift_d    = {1'b0, shift_q[CFG_W-2:1]};
          cfg_i_d    = shift_q[0];
          cfg_en_d   = 1'b1;
          bit_cnt_d  = bit_cnt_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_q == 4'(SETTLE_CYC - 1)) begin
          state_d = run_req ? S_RUN : S_IDLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept || reload) begin
      int_cnt_d = '0;
    end else if (tx_en_q && (int_cnt_q != C_CNT_MAX)) begin
      int_cnt_d = int_cnt_q + 1'b1;
    end else begin
      int_cnt_d = int_cnt_q;
    end

    // Enables stop as soon as the interval is used up so the reload edge
    // follows exactly REKEY_INT enabled TX cycles.
    en_gate = C_REKEY_ON && (int_cnt_d >= C_REKEY_TGT);
    tx_en_d = (state_q == S_RUN) && (state_d == S_RUN) && run_req && tx_req && !en_gate;
    rx_en_d = (state_q == S_RUN) && (state_d == S_RUN) && run_req && rx_req && !en_gate;

    cfg_ready_d = (state_d == S_IDLE) || (state_d == S_RUN);
    busy_d      = (state_d == S_SHIFT) || (state_d == S_SETTLE);
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_en    = cfg_en_q;
  assign cfg_i     = cfg_i_q;
  assign tx_en     = tx_en_q;
  assign rx_en     = rx_en_q;
  assign rb_data   = rb_data_q;
  assign rb_valid  = rb_valid_q;
  assign busy      = busy_q;
  assign rekey_cnt = rekey_q;

endmodule
`default_nettype wire

// File: tb/tb_cipher_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cipher_cfg_sequencer
// Purpose  : Directed and randomized bench for cipher_cfg_sequencer with a
//            behavioural model of the sequencer and of the core's cfg chain.
// Revision : 1.0  initial release
// ============================================================================
module tb_cipher_cfg_sequencer;

  localparam int CFG_W  = 66;
  localparam int SETTLE = 2;
  localparam int REKEY  = 10;
  localparam int CNT_W  = 24;
  localparam logic [CFG_W-1:0] C_CORE_INIT = 66'h3_A5C3_1E0F_9B27_D461;
  localparam logic [CFG_W-1:0] C_W1        = 66'h2_4800_0000_0000_0055;

  localparam int MD_IDLE = 0, MD_LOAD = 1, MD_WAIT = 2, MD_RUN = 3;

  logic             clk = 1'b0;
  logic             rst_n, cfg_valid, run_req, tx_req, rx_req, cfg_o;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_ready, cfg_en, cfg_i, tx_en, rx_en, rb_valid, busy;
  logic [CFG_W-1:0] rb_data;
  logic [7:0]       rekey_cnt;

  cipher_cfg_sequencer #(
    .CFG_W(CFG_W), .SETTLE_CYC(SETTLE), .REKEY_INT(REKEY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .run_req(run_req), .tx_req(tx_req), .rx_req(rx_req),
    .cfg_o(cfg_o), .cfg_en(cfg_en), .cfg_i(cfg_i), .tx_en(tx_en), .rx_en(rx_en),
    .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy), .rekey_cnt(rekey_cnt)
  );

  always #5 clk = ~clk;

  // Core cfg chain: shifts in at the MSB, serial readback from bit 0.
  logic [CFG_W-1:0] core_chain = C_CORE_INIT;
  assign cfg_o = core_chain[0];
  always @(posedge clk) if (cfg_en) core_chain <= {cfg_i, core_chain[CFG_W-1:1]};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int               m_mode, m_cnt, m_settle, e_rekey;
  bit               pend[$];
  bit               rbq[$];
  logic [CFG_W-1:0] m_shadow, e_rb_data;
  logic             e_ready, e_cfg_en, e_cfg_i, e_tx, e_rx, e_rb_valid, e_busy;

  task automatic model_reset();
    m_mode = MD_IDLE; m_cnt = 0; m_settle = 0; e_rekey = 0;
    pend.delete(); rbq.delete();
    m_shadow = '0; e_rb_data = '0;
    e_ready = 0; e_cfg_en = 0; e_cfg_i = 0; e_tx = 0; e_rx = 0; e_rb_valid = 0; e_busy = 0;
  endtask

  task automatic model_load(input logic [CFG_W-1:0] w);
    pend.delete(); rbq.delete();
    for (int i = 0; i < CFG_W; i++) pend.push_back(w[i]);
    m_mode = MD_LOAD;
  endtask

  // Advances the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit acc, hit, was_run, reload;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc     = cfg_valid && e_ready;
    hit     = (m_mode == MD_RUN) && (m_cnt >= REKEY);
    was_run = (m_mode == MD_RUN);
    reload  = 0;
    e_rb_valid = 0;
    if (m_mode == MD_LOAD) begin
      rbq.push_back(cfg_o);
      void'(pend.pop_front());
      if (pend.size() == 0) begin
        for (int i = 0; i < CFG_W; i++) e_rb_data[i] = rbq[i];
        e_rb_valid = 1;
        m_mode = MD_WAIT;
        m_settle = SETTLE;
      end
    end else if (m_mode == MD_WAIT) begin
      m_settle--;
      if (m_settle == 0) m_mode = run_req ? MD_RUN : MD_IDLE;
    end else begin
      if (acc) begin
        m_shadow = cfg_data;
        model_load(cfg_data);
      end else if (hit) begin
        reload = 1;
        model_load(m_shadow);
        if (e_rekey < 255) e_rekey++;
      end else if (m_mode == MD_RUN && !run_req) begin
        m_mode = MD_IDLE;
      end
    end
    if (acc || reload) m_cnt = 0;
    else if (e_tx && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    e_tx     = was_run && (m_mode == MD_RUN) && tx_req && (m_cnt < REKEY);
    e_rx     = was_run && (m_mode == MD_RUN) && rx_req && (m_cnt < REKEY);
    e_cfg_en = (m_mode == MD_LOAD);
    e_cfg_i  = e_cfg_en ? pend[0] : 1'b0;
    e_ready  = (m_mode == MD_IDLE) || (m_mode == MD_RUN);
    e_busy   = (m_mode == MD_LOAD) || (m_mode == MD_WAIT);
  endtask

  task automatic compare_all();
    check_eq("cfg_ready", cfg_ready, e_ready);
    check_eq("cfg_en",    cfg_en,    e_cfg_en);
    check_eq("cfg_i",     cfg_i,     e_cfg_i);
    check_eq("tx_en",     tx_en,     e_tx);
    check_eq("rx_en",     rx_en,     e_rx);
    check_eq("rb_data",   rb_data,   e_rb_data);
    check_eq("rb_valid",  rb_valid,  e_rb_valid);
    check_eq("busy",      busy,      e_busy);
    check_eq("rekey_cnt", rekey_cnt, e_rekey);
  endtask

  // Per-phase observation counters
  int         en_cycles, busy_cycles, rbv_pulses, ibits_n;
  logic [8:0] ibits;

  task automatic clear_stats();
    en_cycles = 0; busy_cycles = 0; rbv_pulses = 0; ibits_n = 0; ibits = '0;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
    if (cfg_en) begin
      en_cycles++;
      if (ibits_n < 9) begin
        ibits[ibits_n] = cfg_i;
        ibits_n++;
      end
    end
    if (busy) busy_cycles++;
    if (rb_valid) rbv_pulses++;
  endtask

  function automatic logic [CFG_W-1:0] rand66();
    return {2'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CFG_W-1:0] w_b, w4, w5;
    int  rk;
    bit  found;

    rst_n = 0; cfg_valid = 0; cfg_data = '0; run_req = 0; tx_req = 0; rx_req = 0;
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1;
    tick();
    check_eq("ready_after_reset", cfg_ready, 1'b1);

    // Single load: enable length, bit order, busy length, first readback
    clear_stats();
    cfg_data = C_W1; cfg_valid = 1; tick(); cfg_valid = 0;
    repeat (75) tick();
    check_eq("t1_cfg_en_cycles", en_cycles, CFG_W);
    check_eq("t1_busy_cycles", busy_cycles, CFG_W + SETTLE);
    check_eq("t1_cfg_i_seq", ibits, 9'h055);
    check_eq("t1_rb_core_init", rb_data, C_CORE_INIT);
    check_eq("t1_rb_pulses", rbv_pulses, 1);

    // Second load returns the first word
    w_b = rand66();
    cfg_data = w_b; cfg_valid = 1; tick(); cfg_valid = 0;
    repeat (70) tick();
    check_eq("t2_rb_prev_word", rb_data, C_W1);
    check_eq("t2_core_chain", core_chain, w_b);

    // RUN gating with toggled requests, then drop run_req
    cfg_data = rand66(); run_req = 1; cfg_valid = 1; tick(); cfg_valid = 0;
    repeat (68) tick();
    for (int i = 0; i < 8; i++) begin
      tx_req = 1'($urandom); rx_req = 1'($urandom);
      tick();
    end
    run_req = 0; tick(); tick();
    check_eq("t3_ready_idle", cfg_ready, 1'b1);
    check_eq("t3_tx_off", tx_en, 1'b0);
    tx_req = 0; rx_req = 0;

    // Automatic rekey after REKEY enabled TX cycles
    w4 = rand66();
    cfg_data = w4; run_req = 1; tx_req = 1; cfg_valid = 1; tick(); cfg_valid = 0;
    repeat (100) tick();
    check_eq("t4_rekey_one", rekey_cnt, 8'd1);
    repeat (55) tick();
    check_eq("t4_run_resumed_busy", busy, 1'b0);
    check_eq("t4_run_resumed_tx", tx_en, 1'b1);
    check_eq("t4_core_same_word", core_chain, w4);

    // Host word arriving on the rekey-hit edge wins
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (m_mode == MD_RUN && m_cnt >= REKEY) begin
        found = 1;
        break;
      end
      tick();
    end
    check_eq("t5_hit_reached", found, 1'b1);
    rk = e_rekey;
    w5 = rand66();
    cfg_data = w5; cfg_valid = 1; tick(); cfg_valid = 0;
    check_eq("t5_rekey_unchanged", rekey_cnt, rk);
    repeat (67) tick();
    check_eq("t5_core_new_word", core_chain, w5);
    run_req = 0; tx_req = 0;
    repeat (4) tick();

    // Reset in the middle of a shift
    cfg_data = rand66(); cfg_valid = 1; tick(); cfg_valid = 0;
    repeat (29) tick();
    rst_n = 0; clear_stats(); tick(); rst_n = 1;
    check_eq("t6_cfg_en_off", cfg_en, 1'b0);
    check_eq("t6_busy_off", busy, 1'b0);
    repeat (80) tick();
    check_eq("t6_no_rb_pulse", rbv_pulses, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst_n     = ($urandom_range(0, 499) != 0);
      cfg_valid = ($urandom_range(0, 39) == 0);
      cfg_data  = rand66();
      run_req   = ($urandom_range(0, 9) != 0);
      tx_req    = ($urandom_range(0, 3) != 0);
      rx_req    = 1'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
